// File: rtl/snes_joy_ctrl.sv
// snes_joy_ctrl: polls an SNES-style serial gamepad at a fixed rate and
// converts its 16 active-low serial bits into the gb core's 8-bit
// active-high joystick word, plus the raw 12-button view and a
// pad-present flag.
module snes_joy_ctrl #(
  parameter int POLL_DIV   = 69905,
  parameter int STROBE_LEN = 50,
  parameter int HALF_BIT   = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        joy_data,
  output logic        joy_strobe,
  output logic        joy_clock,
  output logic [7:0]  joystick,
  output logic [11:0] buttons_raw,
  output logic        present,
  output logic        update
);

  localparam int PW   = $clog2(POLL_DIV);
  localparam int TMAX = (STROBE_LEN > HALF_BIT) ? STROBE_LEN : HALF_BIT;
  localparam int TW   = $clog2(TMAX);

  localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] STROBE_LAST = TW'(STROBE_LEN - 1);
  localparam logic [TW-1:0] HALF_LAST   = TW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_SETTLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [PW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tmr_q;
  logic [3:0]     idx_q;
  logic [15:0]    sh_q;
  logic [1:0]     sync_q;
  logic           strobe_q;
  logic           jclk_q;
  logic [7:0]     joy_q;
  logic [11:0]    raw_q;
  logic           present_q;
  logic           update_q;

  logic           tick;
  logic           data_s;
  logic           pad_seen;
  logic [7:0]     joy_map;

  assign tick     = (cnt_q == POLL_LAST);
  assign data_s   = sync_q[1];
  // An unplugged pad leaves the line low, which reads as every bit pressed.
  assign pad_seen = (sh_q != 16'hFFFF);
  // gb order {start, select, B, A, down, up, left, right} from SNES bit order.
  assign joy_map  = {sh_q[3], sh_q[2], sh_q[0], sh_q[8],
                     sh_q[5], sh_q[4], sh_q[6], sh_q[7]};

  assign joy_strobe  = strobe_q;
  assign joy_clock   = jclk_q;
  assign joystick    = joy_q;
  assign buttons_raw = raw_q;
  assign present     = present_q;
  assign update      = update_q;

  // Bring the asynchronous pad data line into the clk domain.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], joy_data};
  end

  // Next value of the free-running poll counter.
  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (cnt_q == POLL_LAST) cnt_d = '0;
  end

  // Poll counter: wraps every POLL_DIV cycles, independent of the FSM.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Frame sequencer: strobe, settle, 15 clock pulses, then publish results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '1;
      strobe_q  <= 1'b0;
      jclk_q    <= 1'b1;
      joy_q     <= '0;
      raw_q     <= '0;
      present_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Ticks that arrive while disabled or busy are simply dropped.
          if (tick && enable) begin
            state_q  <= S_STROBE;
            strobe_q <= 1'b1;
            tmr_q    <= '0;
          end
        end
        S_STROBE: begin
          if (tmr_q == STROBE_LAST) begin
            state_q  <= S_SETTLE;
            strobe_q <= 1'b0;
            tmr_q    <= '0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_SETTLE: begin
          if (tmr_q == HALF_LAST) begin
            sh_q[idx_q] <= ~data_s;
            idx_q       <= idx_q + 4'd1;
            state_q     <= S_LOW;
            jclk_q      <= 1'b0;
            tmr_q       <= '0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_LOW: begin
          // The pad shifts its next bit out on the rising edge that ends LOW.
          if (tmr_q == HALF_LAST) begin
            state_q <= S_HIGH;
            jclk_q  <= 1'b1;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_HIGH: begin
          if (tmr_q == HALF_LAST) begin
            sh_q[idx_q] <= ~data_s;
            idx_q       <= idx_q + 4'd1;
            tmr_q       <= '0;
            if (idx_q == 4'd15) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_LOW;
              jclk_q  <= 1'b0;
            end
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_DONE: begin
          raw_q     <= sh_q[11:0];
          present_q <= pad_seen;
          joy_q     <= pad_seen ? joy_map : 8'h00;
          update_q  <= 1'b1;
          idx_q     <= '0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
